// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and default sizes for the bus-2 initiator.
//   c2_cmd_e : encodings carried on the shared C2 command wires
//   state_e  : sequencer states of mem_bus_master
//   *_DEF    : default geometry (16-byte line of eight 16-bit words)
package mem_bus_pkg;

    localparam int ADDR_W_DEF     = 14;
    localparam int DATA_W_DEF     = 16;
    localparam int LINE_WORDS_DEF = 8;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_WAIT = 3'd2,
        WR_DATA = 3'd3,
        WR_WAIT = 3'd4,
        TURN    = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/bus2_tristate_port.sv
// bus2_tristate_port: output-enable and release of the shared bus-2 wires.
//   c2_oe/c2_out : drive C2 with c2_out when c2_oe, otherwise release to z
//   d2_oe/d2_out : drive D2 with d2_out when d2_oe, otherwise release to z
//   c2_in/d2_in  : resolved bus values as seen on the wires
//   c2/d2        : the shared inout wires
module bus2_tristate_port #(
    parameter int DATA_W = 16
) (
    input  logic              c2_oe,
    input  logic [1:0]        c2_out,
    input  logic              d2_oe,
    input  logic [DATA_W-1:0] d2_out,
    output logic [1:0]        c2_in,
    output logic [DATA_W-1:0] d2_in,
    inout  wire  [1:0]        c2,
    inout  wire  [DATA_W-1:0] d2
);

    assign c2    = c2_oe ? c2_out : {2{1'bz}};
    assign d2    = d2_oe ? d2_out : {DATA_W{1'bz}};
    assign c2_in = c2;
    assign d2_in = d2;

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: cache-side initiator of the bus-2 line-transfer protocol.
// Takes one whole-line read or write from cache logic, runs the A2/D2/C2
// command, burst and turnaround sequence, then returns the line or an error.
//   CLK, RESET_N            : clock (posedge), async active-low reset
//   REQ_VALID/REQ_READY     : request handshake; a request transfers on a
//                             rising edge where both are 1. READY is high
//                             only in IDLE and in the RESP_VALID cycle.
//   REQ_WRITE/ADDR/WDATA    : request contents, word 0 in WDATA LSBs
//   RESP_VALID/RDATA/ERR    : one-cycle completion pulse; RDATA holds the
//                             last good read line, ERR=1 means timeout
//   A2, D2, C2              : bus-2 address, data and command wires
//   DBG_STATE               : current sequencer state
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic                         REQ_WRITE,
    input  logic [ADDR_W-1:0]            REQ_ADDR,
    input  logic [DATA_W*LINE_WORDS-1:0] REQ_WDATA,
    output logic                         RESP_VALID,
    output logic [DATA_W*LINE_WORDS-1:0] RESP_RDATA,
    output logic                         RESP_ERR,
    output logic [ADDR_W-1:0]            A2,
    inout  wire  [DATA_W-1:0]            D2,
    inout  wire  [1:0]                   C2,
    output state_e                       DBG_STATE
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam int LINE_W = DATA_W * LINE_WORDS;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

    state_e              state, next_state;
    logic [BEAT_W-1:0]   beat;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                first_wait;
    logic                is_write;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   rdata_q;

    logic                c2_oe, d2_oe;
    logic [1:0]          c2_out, c2_in;
    logic [DATA_W-1:0]   d2_out, d2_in;
    logic                accept, waiting, resp_seen, timed_out;

    assign REQ_READY  = (state == IDLE) || (state == DONE);
    assign accept     = REQ_VALID && REQ_READY;
    assign waiting    = (state == RD_WAIT) || (state == WR_WAIT);
    // The cycle right after the master releases C2 is turnaround and is never
    // sampled. Case equality makes a floating or X bus count as NOP.
    assign resp_seen  = waiting && !first_wait && (c2_in === C2_RESPONSE);
    assign timed_out  = waiting && !resp_seen && (wait_cnt == WAIT_LIMIT);

    assign RESP_VALID = (state == DONE);
    assign RESP_ERR   = (state == DONE) && err_q;
    assign RESP_RDATA = rdata_q;
    assign A2         = addr_q;
    assign DBG_STATE  = state;
    assign d2_out     = line_buf[beat*DATA_W +: DATA_W];

    bus2_tristate_port #(.DATA_W(DATA_W)) u_port (
        .c2_oe  (c2_oe),
        .c2_out (c2_out),
        .d2_oe  (d2_oe),
        .d2_out (d2_out),
        .c2_in  (c2_in),
        .d2_in  (d2_in),
        .c2     (C2),
        .d2     (D2)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        c2_oe      = 1'b0;
        c2_out     = C2_NOP;
        d2_oe      = 1'b0;
        case (state)
            IDLE, DONE: begin
                c2_oe = 1'b1;
                if (accept) begin
                    next_state = REQ_WRITE ? WR_DATA : RD_CMD;
                end else begin
                    next_state = IDLE;
                end
            end
            RD_CMD: begin
                c2_oe      = 1'b1;
                c2_out     = C2_READ_LINE;
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                if ((resp_seen && (beat == LAST_BEAT)) || timed_out) begin
                    next_state = TURN;
                end
            end
            WR_DATA: begin
                c2_oe  = 1'b1;
                c2_out = C2_WRITE_LINE;
                d2_oe  = 1'b1;
                if (beat == LAST_BEAT) begin
                    next_state = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (resp_seen || timed_out) begin
                    next_state = TURN;
                end
            end
            TURN:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            beat       <= '0;
            wait_cnt   <= '0;
            first_wait <= 1'b0;
            is_write   <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            line_buf   <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                addr_q   <= REQ_ADDR;
                line_buf <= REQ_WDATA;
                is_write <= REQ_WRITE;
                err_q    <= 1'b0;
                beat     <= '0;
            end
            // Leaving the driving phase: arm the turnaround flag and the timer.
            if ((state == RD_CMD) || ((state == WR_DATA) && (beat == LAST_BEAT))) begin
                first_wait <= 1'b1;
                wait_cnt   <= '0;
                beat       <= '0;
            end else if (state == WR_DATA) begin
                beat <= beat + 1'b1;
            end
            if (waiting) begin
                first_wait <= 1'b0;
                if (resp_seen) begin
                    // Timer measures silence since the last beat.
                    wait_cnt <= '0;
                    if (!is_write) begin
                        line_buf[beat*DATA_W +: DATA_W] <= d2_in;
                        beat <= beat + 1'b1;
                    end
                end else if (timed_out) begin
                    err_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            // The visible read line changes only on a successful read.
            if ((state == TURN) && !err_q && !is_write) begin
                rdata_q <= line_buf;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed bench for mem_bus_master with a bus-2 responder
// model; responses are scored against an expected queue.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int TIMEOUT = 255;
    localparam int W = 129;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [13:0]   REQ_ADDR;
    logic [127:0]  REQ_WDATA;
    logic          RESP_VALID;
    logic [127:0]  RESP_RDATA;
    logic          RESP_ERR;
    logic [13:0]   A2;
    wire  [15:0]   D2;
    wire  [1:0]    C2;
    state_e        dbg_state;

    logic          tb_c2_oe = 1'b0;
    logic [1:0]    tb_c2 = 2'b00;
    logic          tb_d2_oe = 1'b0;
    logic [15:0]   tb_d2 = 16'h0000;

    assign C2 = tb_c2_oe ? tb_c2 : 2'bzz;
    assign D2 = tb_d2_oe ? tb_d2 : 16'hzzzz;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic [127:0] model_rdata = '0;

    mem_bus_master #(
        .ADDR_W(14), .DATA_W(16), .LINE_WORDS(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WRITE  (REQ_WRITE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .RESP_VALID (RESP_VALID),
        .RESP_RDATA (RESP_RDATA),
        .RESP_ERR   (RESP_ERR),
        .A2         (A2),
        .D2         (D2),
        .C2         (C2),
        .DBG_STATE  (dbg_state)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: act=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Checking helpers
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic bit no_ones(input logic [15:0] v);
        return !((|v) === 1'b1);
    endfunction

    // Scoreboard monitor: pops one expectation per completion pulse.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && RESP_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: act=%h exp=none", {RESP_ERR, RESP_RDATA});
            end else begin
                chk("resp", {RESP_ERR, RESP_RDATA}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic bus_idle();
        tb_c2_oe = 1'b0;
        tb_d2_oe = 1'b0;
    endtask

    // While the master should be released, the responder holds NOP/0 so a
    // master that keeps driving shows up as a changed or unknown value.
    task automatic probe_on();
        tb_c2_oe = 1'b1;
        tb_c2    = C2_NOP;
        tb_d2_oe = 1'b1;
        tb_d2    = 16'h0000;
    endtask

    task automatic issue(input bit wr, input logic [13:0] addr, input logic [127:0] wdata, output bit ok);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (REQ_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_wait: act=ready_low state=%0d exp=ready_high", dbg_state);
        end else begin
            @(posedge CLK);
        end
    endtask

    task automatic finish_resp(input bit keep);
        @(negedge CLK);
        chk("turn_no_resp", RESP_VALID, 0);
        chk("turn_c2_released", C2, 0);
        @(posedge CLK);
        #1 bus_idle();
        @(negedge CLK);
        chk("done_valid", RESP_VALID, 1);
        chk("done_c2_nop", C2, C2_NOP);
        chk("done_ready", REQ_READY, 1);
        if (!keep) begin
            @(negedge CLK);
            chk("pulse_one_cycle", RESP_VALID, 0);
            chk("ready_after", REQ_READY, 1);
        end
    endtask

    task automatic do_read(input logic [13:0] addr, input logic [127:0] line, input int lat,
                           input logic [7:0] gaps, input int abort_beat, input bit keep);
        bit ok;
        if (abort_beat < 0) begin
            exp_q.push_back({1'b0, line});
            model_rdata = line;
        end
        issue(1'b0, addr, '0, ok);
        if (!ok) return;
        #1;
        if (!keep) REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("rd_cmd_c2", C2, C2_READ_LINE);
        chk("rd_cmd_a2", A2, addr);
        @(posedge CLK);
        #1 probe_on();
        @(negedge CLK);
        chk("rd_turn_c2", C2, 0);
        chk("rd_turn_d2", D2, 0);
        repeat (lat) @(posedge CLK);
        for (int k = 0; k < 8; k++) begin
            #1;
            if (gaps[k]) begin
                tb_c2 = C2_NOP;
                tb_d2 = 16'hDEAD;
                @(posedge CLK);
                #1;
            end
            tb_c2 = C2_RESPONSE;
            tb_d2 = line[k*16 +: 16];
            if (k == abort_beat) begin
                #2;
                RESET_N = 1'b0;
                bus_idle();
                #1;
                chk("rst_c2_nop", C2, C2_NOP);
                chk("rst_d2_released", no_ones(D2), 1);
                chk("rst_ready", REQ_READY, 1);
                chk("rst_no_valid", RESP_VALID, 0);
                chk("rst_rdata", RESP_RDATA, 0);
                chk("rst_a2", A2, 0);
                model_rdata = '0;
                @(negedge CLK);
                @(negedge CLK);
                RESET_N = 1'b1;
                return;
            end
            @(posedge CLK);
        end
        #1 probe_on();
        finish_resp(keep);
    endtask

    task automatic do_write(input logic [13:0] addr, input logic [127:0] line, input int lat);
        bit ok;
        exp_q.push_back({1'b0, model_rdata});
        issue(1'b1, addr, line, ok);
        if (!ok) return;
        #1 REQ_VALID = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            chk("wr_c2", C2, C2_WRITE_LINE);
            chk("wr_d2", D2, line[k*16 +: 16]);
            if (k == 0) chk("wr_a2", A2, addr);
            @(posedge CLK);
        end
        #1 probe_on();
        @(negedge CLK);
        chk("wr_wait_c2", C2, 0);
        chk("wr_wait_d2", D2, 0);
        repeat (lat) @(posedge CLK);
        #1 tb_c2 = C2_RESPONSE;
        @(posedge CLK);
        #1 tb_c2 = C2_NOP;
        finish_resp(1'b0);
    endtask

    // Responder stays silent apart from READ/WRITE codes, which must be ignored.
    task automatic do_timeout(input logic [13:0] addr);
        bit ok;
        exp_q.push_back({1'b1, model_rdata});
        issue(1'b0, addr, '0, ok);
        if (!ok) return;
        #1 REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        tb_c2_oe = 1'b1;
        tb_d2_oe = 1'b1;
        tb_d2    = 16'hBAD0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tb_c2 = (i % 2 == 0) ? C2_READ_LINE : C2_WRITE_LINE;
            @(posedge CLK);
            #1;
        end
        bus_idle();
        @(negedge CLK);
        chk("to_turn_no_resp", RESP_VALID, 0);
        @(negedge CLK);
        chk("to_done_valid", RESP_VALID, 1);
        chk("to_done_ready", REQ_READY, 1);
        @(negedge CLK);
        chk("to_pulse_one_cycle", RESP_VALID, 0);
        chk("to_ready_after", REQ_READY, 1);
    endtask

    // Directed sequence
    initial begin
        logic [127:0] line1, wline, line2, line3, line4, line5;
        line1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        wline = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_8796;
        line2 = 128'hA008_A007_A006_A005_A004_A003_A002_A001;
        line3 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        line4 = 128'hCAFE_BABE_DEAD_BEEF_0123_4567_89AB_CDEF;
        line5 = 128'h0001_0002_0004_0008_0010_0020_0040_0080;

        RESET_N   = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        #1;
        chk("reset_ready", REQ_READY, 1);
        chk("reset_valid", RESP_VALID, 0);
        chk("reset_err", RESP_ERR, 0);
        chk("reset_rdata", RESP_RDATA, 0);
        chk("reset_a2", A2, 0);
        chk("reset_c2_nop", C2, C2_NOP);
        chk("reset_d2_released", no_ones(D2), 1);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        do_read(14'h155, line1, 3, 8'h00, -1, 1'b0);
        do_write(14'h2A5, wline, 2);
        do_read(14'h0F0, line2, 1, 8'b0010_0100, -1, 1'b0);
        do_timeout(14'h3FF);
        do_read(14'h011, line3, 2, 8'h00, 4, 1'b0);
        @(negedge CLK);
        do_read(14'h022, line3, 3, 8'h00, -1, 1'b0);
        do_read(14'h100, line4, 2, 8'h00, -1, 1'b1);
        do_read(14'h200, line5, 1, 8'h00, -1, 1'b0);

        repeat (3) @(negedge CLK);
        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
